// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// Build option: ALU_ARBITER_OPCHECK_EN enables illegal-opcode rejection in the top.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD        = 4'd0;
    localparam logic [3:0] OP_SUB        = 4'd1;
    localparam logic [3:0] OP_MUL        = 4'd2;
    localparam logic [3:0] OP_OR         = 4'd3;
    localparam logic [3:0] OP_AND        = 4'd4;
    localparam logic [3:0] OP_XOR        = 4'd5;
    localparam logic [3:0] OP_SHR        = 4'd6;
    localparam logic [3:0] OP_SHL        = 4'd7;
    localparam logic [3:0] OP_ROR        = 4'd8;
    localparam logic [3:0] OP_CMP        = 4'd9;
    localparam logic [3:0] OP_LAST_LEGAL = 4'd9;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    // Counter preload: EXEC lasts (preload + 1) cycles.
    function automatic logic [3:0] exec_cnt_init(input logic [3:0] op,
                                                 input int       mul_cycles,
                                                 input int       alu_cycles);
        if (op == OP_MUL)
            exec_cnt_init = 4'(mul_cycles - 1);
        else
            exec_cnt_init = 4'(alu_cycles - 1);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter_2.sv
// Two-input round-robin grant, purely combinational (zero latency).
// The port that was not granted last wins a tie; no grant without a valid.
module rr_arbiter_2
    import alu_arbiter_pkg::*;
(
    input  logic [1:0] i_req_vld,
    input  logic       i_rr_last,
    output logic [1:0] o_gnt,
    output logic       o_gnt_id
);

    always_comb begin
        o_gnt    = 2'b00;
        o_gnt_id = 1'b0;
        if (i_req_vld == 2'b11) begin
            o_gnt_id = ~i_rr_last;
            o_gnt    = i_rr_last ? 2'b01 : 2'b10;
        end else if (i_req_vld[1]) begin
            o_gnt_id = 1'b1;
            o_gnt    = 2'b10;
        end else if (i_req_vld[0]) begin
            o_gnt    = 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters; response 1+N cycles after accept.
// Requests only accepted in IDLE; response held until resp_ready. ALU_ARBITER_OPCHECK_EN adds resp_err.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int MUL_CYCLES = 3,
    parameter int ALU_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_shift,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_shift,
    output logic [3:0]  alu_optcode,
    output logic [31:0] alu_r2,
    output logic [31:0] alu_r3,
    output logic [4:0]  alu_shift,
    input  logic [31:0] alu_r1,
    input  logic [3:0]  alu_flags,
`ifdef ALU_ARBITER_OPCHECK_EN
    output logic        resp_err,
`endif
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data,
    output logic [3:0]  resp_flags
);

    state_t      r_state;
    logic        r_rr_last;
    logic [3:0]  r_cnt;
    logic [3:0]  r_alu_op;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [4:0]  r_alu_shift;
    logic        r_id;
    logic        r_resp_vld;
    logic [31:0] r_resp_data;
    logic [3:0]  r_resp_flags;

    logic [1:0]  w_gnt;
    logic        w_gnt_id;
    logic        w_accept;
    logic        w_illegal;
    logic [3:0]  w_sel_op;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;
    logic [4:0]  w_sel_shift;

    rr_arbiter_2 u_rr (
        .i_req_vld ({req1_valid, req0_valid}),
        .i_rr_last (r_rr_last),
        .o_gnt     (w_gnt),
        .o_gnt_id  (w_gnt_id)
    );

    assign req0_ready  = (r_state == ST_IDLE) && w_gnt[0];
    assign req1_ready  = (r_state == ST_IDLE) && w_gnt[1];
    assign w_accept    = req0_ready || req1_ready;

    assign w_sel_op    = w_gnt_id ? req1_op    : req0_op;
    assign w_sel_a     = w_gnt_id ? req1_a     : req0_a;
    assign w_sel_b     = w_gnt_id ? req1_b     : req0_b;
    assign w_sel_shift = w_gnt_id ? req1_shift : req0_shift;

`ifdef ALU_ARBITER_OPCHECK_EN
    logic r_resp_err;
    assign w_illegal = (w_sel_op > OP_LAST_LEGAL);
    assign resp_err  = r_resp_err;

    always_ff @(posedge clk) begin
        if (reset)
            r_resp_err <= 1'b0;
        else if (r_state == ST_IDLE && w_accept)
            r_resp_err <= w_illegal;
    end
`else
    assign w_illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rr_last    <= 1'b1;
            r_cnt        <= 4'd0;
            r_alu_op     <= 4'd0;
            r_alu_a      <= 32'd0;
            r_alu_b      <= 32'd0;
            r_alu_shift  <= 5'd0;
            r_id         <= 1'b0;
            r_resp_vld   <= 1'b0;
            r_resp_data  <= 32'd0;
            r_resp_flags <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id      <= w_gnt_id;
                        r_rr_last <= w_gnt_id;
                        if (w_illegal) begin
                            // Rejected opcode: answer immediately, ALU inputs untouched.
                            r_resp_data  <= 32'd0;
                            r_resp_flags <= 4'd0;
                            r_resp_vld   <= 1'b1;
                            r_state      <= ST_RESP;
                        end else begin
                            r_alu_op    <= w_sel_op;
                            r_alu_a     <= w_sel_a;
                            r_alu_b     <= w_sel_b;
                            r_alu_shift <= w_sel_shift;
                            r_cnt       <= exec_cnt_init(w_sel_op, MUL_CYCLES, ALU_CYCLES);
                            r_state     <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_resp_data  <= alu_r1;
                        r_resp_flags <= alu_flags;
                        r_resp_vld   <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_vld <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign alu_optcode = r_alu_op;
    assign alu_r2      = r_alu_a;
    assign alu_r3      = r_alu_b;
    assign alu_shift   = r_alu_shift;
    assign resp_valid  = r_resp_vld;
    assign resp_id     = r_id;
    assign resp_data   = r_resp_data;
    assign resp_flags  = r_resp_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the alu_* ports.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_shift, req1_shift;
    logic [3:0]  alu_optcode;
    logic [31:0] alu_r2, alu_r3, alu_r1;
    logic [4:0]  alu_shift;
    logic [3:0]  alu_flags;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_data;
    logic [3:0]  resp_flags;
`ifdef ALU_ARBITER_OPCHECK_EN
    logic        resp_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.MUL_CYCLES(3), .ALU_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_shift(req0_shift),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_shift(req1_shift),
        .alu_optcode(alu_optcode), .alu_r2(alu_r2), .alu_r3(alu_r3),
        .alu_shift(alu_shift), .alu_r1(alu_r1), .alu_flags(alu_flags),
`ifdef ALU_ARBITER_OPCHECK_EN
        .resp_err(resp_err),
`endif
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_flags(resp_flags)
    );

    // Behavioural ALU; unknown opcodes return a recognisable pattern.
    logic [32:0] m_sum;
    logic [31:0] m_res;
    logic        m_v, m_c;
    always_comb begin
        m_sum = 33'd0;
        m_res = 32'hDEADBEEF;
        m_v   = 1'b0;
        m_c   = 1'b0;
        case (alu_optcode)
            4'd0: begin
                m_sum = {1'b0, alu_r2} + {1'b0, alu_r3};
                m_res = m_sum[31:0];
                m_c   = m_sum[32];
                m_v   = (alu_r2[31] == alu_r3[31]) && (m_res[31] != alu_r2[31]);
            end
            4'd1, 4'd9: begin
                m_res = alu_r2 - alu_r3;
                m_c   = alu_r2 < alu_r3;
                m_v   = (alu_r2[31] != alu_r3[31]) && (m_res[31] != alu_r2[31]);
            end
            4'd2: m_res = alu_r2 * alu_r3;
            4'd3: m_res = alu_r2 | alu_r3;
            4'd4: m_res = alu_r2 & alu_r3;
            4'd5: m_res = alu_r2 ^ alu_r3;
            4'd6: m_res = alu_r2 >> alu_shift;
            4'd7: m_res = alu_r2 << alu_shift;
            4'd8: m_res = (alu_r2 >> alu_shift) | (alu_r2 << (6'd32 - {1'b0, alu_shift}));
            default: m_res = 32'hDEADBEEF;
        endcase
        alu_r1    = m_res;
        alu_flags = {m_res[31], m_res == 32'd0, m_v, m_c};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; resp_ready = 1'b1;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0; req0_shift = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0; req1_shift = 0;
        step();
        do_reset();

        // Reset state
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_flags", resp_flags, 0);
        chk("rst_alu_op", alu_optcode, 0);
        chk("rst_alu_r2", alu_r2, 0);
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);

        // Add on port 0 only
        req0_valid = 1; req0_op = 4'd0; req0_a = 5; req0_b = 7;
        #1;
        chk("add_rdy0", req0_ready, 1);
        chk("add_rdy1", req1_ready, 0);
        step();
        req0_valid = 0;
        #1;
        chk("add_exec_vld", resp_valid, 0);
        chk("add_exec_rdy1", req1_ready, 0);
        chk("add_alu_r2", alu_r2, 5);
        chk("add_alu_r3", alu_r3, 7);
        step();
        chk("add_vld", resp_valid, 1);
        chk("add_id", resp_id, 0);
        chk("add_data", resp_data, 12);
        chk("add_flags", resp_flags, 4'b0000);
        chk("add_resp_rdy1", req1_ready, 0);
        step();
        chk("add_done_vld", resp_valid, 0);

        // Simultaneous requests after reset: port 0, then port 1, then port 0
        do_reset();
        req0_valid = 1; req0_op = 4'd1; req0_a = 3;     req0_b = 3;
        req1_valid = 1; req1_op = 4'd3; req1_a = 32'hF0; req1_b = 32'h0F;
        #1;
        chk("both_rdy0", req0_ready, 1);
        chk("both_rdy1", req1_ready, 0);
        step();
        chk("both_exec_rdy0", req0_ready, 0);
        chk("both_exec_rdy1", req1_ready, 0);
        step();
        chk("sub_vld", resp_valid, 1);
        chk("sub_id", resp_id, 0);
        chk("sub_data", resp_data, 0);
        chk("sub_flags", resp_flags, 4'b0100);
        step();
        chk("alt1_rdy0", req0_ready, 0);
        chk("alt1_rdy1", req1_ready, 1);
        step();
        step();
        chk("or_vld", resp_valid, 1);
        chk("or_id", resp_id, 1);
        chk("or_data", resp_data, 32'h000000FF);
        chk("or_flags", resp_flags, 4'b0000);
        step();
        chk("alt2_rdy0", req0_ready, 1);
        chk("alt2_rdy1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        #1;
        chk("drop_rdy0", req0_ready, 0);
        step();

        // Multiply held for three EXEC cycles
        req0_valid = 1; req0_op = 4'd2; req0_a = 6; req0_b = 7;
        #1;
        chk("mul_rdy0", req0_ready, 1);
        step();
        req0_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("mul_exec_vld", resp_valid, 0);
            chk("mul_exec_op", alu_optcode, 2);
            chk("mul_exec_r2", alu_r2, 6);
            chk("mul_exec_r3", alu_r3, 7);
            step();
        end
        chk("mul_vld", resp_valid, 1);
        chk("mul_data", resp_data, 42);
        step();

        // Backpressure on the response channel
        resp_ready = 0;
        req1_valid = 1; req1_op = 4'd4; req1_a = 32'hFF00; req1_b = 32'h0FF0;
        #1;
        chk("bp_rdy1", req1_ready, 1);
        step();
        req1_valid = 0;
        req0_valid = 1; req0_op = 4'd2; req0_a = 9; req0_b = 9;
        #1;
        chk("bp_exec_rdy0", req0_ready, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", resp_valid, 1);
            chk("bp_data", resp_data, 32'h00000F00);
            chk("bp_id", resp_id, 1);
            chk("bp_flags", resp_flags, 0);
            chk("bp_rdy0", req0_ready, 0);
            step();
        end
        resp_ready = 1;
        #1;
        chk("bp_last_vld", resp_valid, 1);
        chk("bp_last_rdy0", req0_ready, 0);
        step();
        chk("bp_idle_vld", resp_valid, 0);
        chk("bp_idle_rdy0", req0_ready, 1);

        // Reset while a multiply is executing
        step();
        req0_valid = 0;
        step();
        chk("rexec_op", alu_optcode, 2);
        reset = 1;
        step();
        reset = 0;
        chk("rexec_vld", resp_valid, 0);
        chk("rexec_op0", alu_optcode, 0);
        chk("rexec_r2", alu_r2, 0);
        chk("rexec_r3", alu_r3, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rexec_no_resp", resp_valid, 0);
        end

        // Opcode 12 from port 1
        req1_valid = 1; req1_op = 4'd12; req1_a = 32'h1234; req1_b = 1;
        #1;
        chk("ill_rdy1", req1_ready, 1);
        step();
        req1_valid = 0;
`ifdef ALU_ARBITER_OPCHECK_EN
        chk("ill_vld", resp_valid, 1);
        chk("ill_err", resp_err, 1);
        chk("ill_data", resp_data, 0);
        chk("ill_flags", resp_flags, 0);
        chk("ill_id", resp_id, 1);
        chk("ill_alu_op", alu_optcode, 0);
        chk("ill_alu_r2", alu_r2, 0);
        step();
        chk("ill_done_vld", resp_valid, 0);
`else
        chk("ill_exec_vld", resp_valid, 0);
        chk("ill_alu_op", alu_optcode, 12);
        step();
        chk("ill_vld", resp_valid, 1);
        chk("ill_data", resp_data, 32'hDEADBEEF);
        chk("ill_flags", resp_flags, 4'b1000);
        chk("ill_id", resp_id, 1);
        step();
        chk("ill_done_vld", resp_valid, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
